// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and write-back mux; the registered write also serves as the WB forward source.
// Optional retired-instruction counter enabled by defining WB_RETIRE_COUNT_EN.
module mem_wb_writeback #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Valid_in_MEMWB,
   input  logic              Stall_in_MEMWB,
   input  logic              Flush_in_MEMWB,
   input  logic              RegWrite_in_MEMWB,
   input  logic              MemtoReg_in_MEMWB,
   input  logic [DATA_W-1:0] ReadData_in_MEMWB,
   input  logic [DATA_W-1:0] ALUResult_in_MEMWB,
   input  logic [REG_AW-1:0] WriteReg_in_MEMWB,
   output logic              Valid_out_WB,
   output logic              RegWrite_out_WB,
   output logic [REG_AW-1:0] WriteReg_out_WB,
   output logic [DATA_W-1:0] WriteData_out_WB,
   output logic [CNT_W-1:0]  RetireCount_out_WB
);

   logic              validQ;
   logic              regWriteQ;
   logic              memtoRegQ;
   logic [DATA_W-1:0] readDataQ;
   logic [DATA_W-1:0] aluResultQ;
   logic [REG_AW-1:0] writeRegQ;

   // Flush beats stall so a squashed entry can never be held in WB.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         validQ     <= 1'b0;
         regWriteQ  <= 1'b0;
         memtoRegQ  <= 1'b0;
         readDataQ  <= '0;
         aluResultQ <= '0;
         writeRegQ  <= '0;
      end else if (Flush_in_MEMWB) begin
         validQ     <= 1'b0;
         regWriteQ  <= 1'b0;
         memtoRegQ  <= 1'b0;
         readDataQ  <= '0;
         aluResultQ <= '0;
         writeRegQ  <= '0;
      end else if (!Stall_in_MEMWB) begin
         validQ     <= Valid_in_MEMWB;
         regWriteQ  <= RegWrite_in_MEMWB;
         memtoRegQ  <= MemtoReg_in_MEMWB;
         readDataQ  <= ReadData_in_MEMWB;
         aluResultQ <= ALUResult_in_MEMWB;
         writeRegQ  <= WriteReg_in_MEMWB;
      end
   end

   assign Valid_out_WB     = validQ;
   assign WriteReg_out_WB  = writeRegQ;
   assign WriteData_out_WB = memtoRegQ ? readDataQ : aluResultQ;
   // $0 is hardwired to zero, so writes to it are dropped here rather than in the register file.
   assign RegWrite_out_WB  = validQ & regWriteQ & (writeRegQ != '0);

`ifdef WB_RETIRE_COUNT_EN
   logic [CNT_W-1:0] retireCnt;

   // An instruction retires on the edge where it leaves WB, so each is counted once.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)
         retireCnt <= '0;
      else if (validQ && !Stall_in_MEMWB && !Flush_in_MEMWB)
         retireCnt <= retireCnt + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   assign RetireCount_out_WB = retireCnt;
`else
   assign RetireCount_out_WB = '0;
`endif

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Self-checking bench for mem_wb_writeback: directed vector table, hand sequences and a randomized
// run against a behavioural model. Counter expectations follow WB_RETIRE_COUNT_EN.
module tb_mem_wb_writeback;

   logic        Clk;
   logic        Rst_n;
   logic        vIn, stIn, flIn, rwIn, m2rIn;
   logic [31:0] rdIn, aluIn;
   logic [4:0]  wrIn;
   logic        vOut, rwOut;
   logic [4:0]  wrOut;
   logic [31:0] wdOut;
   logic [3:0]  cntOut;

   int total = 0;
   int bad   = 0;

`ifdef WB_RETIRE_COUNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   mem_wb_writeback #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut (
      .Clk                (Clk),
      .Rst_n              (Rst_n),
      .Valid_in_MEMWB     (vIn),
      .Stall_in_MEMWB     (stIn),
      .Flush_in_MEMWB     (flIn),
      .RegWrite_in_MEMWB  (rwIn),
      .MemtoReg_in_MEMWB  (m2rIn),
      .ReadData_in_MEMWB  (rdIn),
      .ALUResult_in_MEMWB (aluIn),
      .WriteReg_in_MEMWB  (wrIn),
      .Valid_out_WB       (vOut),
      .RegWrite_out_WB    (rwOut),
      .WriteReg_out_WB    (wrOut),
      .WriteData_out_WB   (wdOut),
      .RetireCount_out_WB (cntOut)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic v, st, fl, rw, m2r;
      logic [31:0] rd, alu;
      logic [4:0]  wr;
      logic eV, eRw;
      logic [4:0]  eWr;
      logic [31:0] eWd;
   } vec_t;

   // The instruction currently held in WB, as the model understands it.
   typedef struct {
      logic valid, rw, m2r;
      logic [31:0] rd, alu;
      logic [4:0]  wr;
   } entry_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, st, fl, rw, m2r, input logic [31:0] rd, alu, input logic [4:0] wr);
      vIn = v; stIn = st; flIn = fl; rwIn = rw; m2rIn = m2r; rdIn = rd; aluIn = alu; wrIn = wr;
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chkZero(input string tag);
      chk({tag, "_valid"}, {31'd0, vOut}, 32'd0);
      chk({tag, "_rw"},    {31'd0, rwOut}, 32'd0);
      chk({tag, "_wr"},    {27'd0, wrOut}, 32'd0);
      chk({tag, "_wd"},    wdOut, 32'd0);
      chk({tag, "_cnt"},   {28'd0, cntOut}, 32'd0);
   endtask

   // Reset with inputs toggling; release takes effect just after a rising edge.
   task automatic doReset();
      Rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
         step();
         chkZero("reset");
      end
      Rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   vec_t   tbl [11];
   entry_t m, nxt;
   logic [3:0]  mCnt;
   logic [31:0] expWd;
   logic        expRw;

   initial begin
      tbl[0]  = '{1,0,0,1,0, 32'h0,        32'h0000_1234, 5'd5,  1,1,5'd5, 32'h0000_1234};
      tbl[1]  = '{1,0,0,1,1, 32'hDEAD_BEEF, 32'h10,       5'd9,  1,1,5'd9, 32'hDEAD_BEEF};
      tbl[2]  = '{1,0,0,1,0, 32'h0,        32'hFFFF_FFFF, 5'd0,  1,0,5'd0, 32'hFFFF_FFFF};
      tbl[3]  = '{1,0,0,1,0, 32'h0,        32'h42,        5'd7,  1,1,5'd7, 32'h42};
      tbl[4]  = '{1,1,0,1,0, 32'h0,        32'h99,        5'd12, 1,1,5'd7, 32'h42};
      tbl[5]  = '{0,1,0,0,1, 32'h77,       32'h98,        5'd13, 1,1,5'd7, 32'h42};
      tbl[6]  = '{1,1,0,1,1, 32'h55,       32'h97,        5'd14, 1,1,5'd7, 32'h42};
      tbl[7]  = '{1,1,1,1,0, 32'h0,        32'h96,        5'd15, 0,0,5'd0, 32'h0};
      tbl[8]  = '{0,0,0,1,0, 32'h0,        32'h55,        5'd3,  0,0,5'd3, 32'h55};
      tbl[9]  = '{1,0,1,1,0, 32'h0,        32'h66,        5'd8,  0,0,5'd0, 32'h0};
      tbl[10] = '{1,0,0,0,1, 32'hABCD,     32'h1,         5'd4,  1,0,5'd4, 32'hABCD};

      Rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      doReset();

      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].v, tbl[i].st, tbl[i].fl, tbl[i].rw, tbl[i].m2r, tbl[i].rd, tbl[i].alu, tbl[i].wr);
         step();
         chk($sformatf("vec%0d_valid", i), {31'd0, vOut},  {31'd0, tbl[i].eV});
         chk($sformatf("vec%0d_rw", i),    {31'd0, rwOut}, {31'd0, tbl[i].eRw});
         chk($sformatf("vec%0d_wr", i),    {27'd0, wrOut}, {27'd0, tbl[i].eWr});
         chk($sformatf("vec%0d_wd", i),    wdOut, tbl[i].eWd);
      end

      // Asynchronous reset landing while stall and flush are both up.
      drive(1, 0, 0, 1, 0, 0, 32'h321, 5'd6);
      step();
      chk("pre_async_rw", {31'd0, rwOut}, 32'd1);
      drive(1, 1, 1, 1, 0, 0, 32'h5, 5'd2);
      #2 Rst_n = 1'b0;
      #1 chkZero("async");
      doReset();

      // Randomized run; the model tracks the WB entry and counts retirements as plain events.
      m = '{default: '0};
      mCnt = 4'd0;
      for (int c = 0; c < 300; c++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
               $urandom, $urandom, $urandom, $urandom,
               ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom));
         if (m.valid && !stIn && !flIn) mCnt = mCnt + 4'd1;
         if (flIn)       nxt = '{default: '0};
         else if (stIn)  nxt = m;
         else            nxt = '{vIn, rwIn, m2rIn, rdIn, aluIn, wrIn};
         m = nxt;
         step();
         expWd = m.m2r ? m.rd : m.alu;
         expRw = m.valid && m.rw && (m.wr != 5'd0);
         chk("rnd_valid", {31'd0, vOut},  {31'd0, m.valid});
         chk("rnd_rw",    {31'd0, rwOut}, {31'd0, expRw});
         chk("rnd_wr",    {27'd0, wrOut}, {27'd0, m.wr});
         chk("rnd_wd",    wdOut, expWd);
         chk("rnd_cnt",   {28'd0, cntOut}, CNT_ON ? {28'd0, mCnt} : 32'd0);
      end

      // Twenty back-to-back instructions wrap a 4-bit counter to 4.
      doReset();
      for (int i = 0; i < 20; i++) begin
         drive(1, 0, 0, 1, 0, 0, i, 5'd1);
         step();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("cnt_wrap", {28'd0, cntOut}, CNT_ON ? 32'd4 : 32'd0);
      drive(1, 0, 0, 1, 0, 0, 32'h9, 5'd1);
      step();
      drive(1, 1, 0, 1, 0, 0, 32'hA, 5'd2);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("cnt_stall", {28'd0, cntOut}, CNT_ON ? 32'd4 : 32'd0);
         chk("stall_wd", wdOut, 32'h9);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
